// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  localparam logic [2:0] OP_MUL = 3'b111;

  // Multiply needs a longer settle window than the other ALU ops.
  function automatic int unsigned settle_cycles(input logic [2:0] op,
                                                input int unsigned settle,
                                                input int unsigned mul_settle);
    return (op == OP_MUL) ? mul_settle : settle;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side bundle for the ALU operation sequencer.
// master = requester/consumer plus ALU datapath, slave = the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;

  logic               alu_L;
  logic               alu_M;
  logic               alu_N;
  logic [WIDTH-1:0]   alu_A;
  logic [WIDTH-1:0]   alu_B;
  logic [2*WIDTH-1:0] alu_result;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [2:0]         rsp_op;
  logic [2*WIDTH-1:0] rsp_result;

  logic               busy;
  logic [CNT_W-1:0]   fifo_count;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result,
    input  cmd_ready, alu_L, alu_M, alu_N, alu_A, alu_B,
           rsp_valid, rsp_op, rsp_result, busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result,
    output cmd_ready, alu_L, alu_M, alu_N, alu_A, alu_B,
           rsp_valid, rsp_op, rsp_result, busy, fifo_count
  );

endinterface

// File: rtl/alu_op_sequencer_fifo.sv
// Command queue: DEPTH-entry synchronous FIFO with registered occupancy.
// Read data is the current head, valid whenever empty is low.
module alu_seq_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side driver for the combinational ALU: queues requests, holds each
// one on the ALU inputs for its settle window, then returns the captured
// result on a valid/ready response channel.
//
// state | meaning
// IDLE  | no op in flight; ALU inputs parked at zero
// DRIVE | ALU inputs held, settle counter running down
// RESP  | result captured, waiting for rsp_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int SETTLE     = 1,
  parameter int MUL_SETTLE = 4
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);
  localparam int EW = 3 + 2 * WIDTH;
  localparam int CW = $clog2(MUL_SETTLE) + 1;

  seq_state_e         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               rsp_valid;
  logic [2:0]         rsp_op;
  logic [2*WIDTH-1:0] rsp_result;
  logic               ready_en;

  logic               full;
  logic               empty;
  logic [$clog2(DEPTH):0] count;
  logic [EW-1:0]      head;
  logic [2:0]         head_op;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               push;
  logic               pop;
  logic [CW-1:0]      head_cnt;

  assign head_op  = head[EW-1 -: 3];
  assign head_a   = head[2*WIDTH-1 -: WIDTH];
  assign head_b   = head[WIDTH-1:0];
  assign head_cnt = CW'(settle_cycles(head_op, SETTLE, MUL_SETTLE) - 1);

  // Full blocks acceptance even when a pop lands in the same cycle.
  assign bus.cmd_ready = ready_en & ~full;
  assign push = bus.cmd_valid & bus.cmd_ready;
  assign pop  = ~empty & ((state == IDLE) | ((state == RESP) & bus.rsp_ready));

  alu_seq_fifo #(
    .DW   (EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Keeps cmd_ready low during reset and until the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Sequencing FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_op <= head_op;
            alu_a  <= head_a;
            alu_b  <= head_b;
            cnt    <= head_cnt;
            state  <= DRIVE;
          end else begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_op    <= alu_op;
            // Upper half is only meaningful for multiply.
            if (alu_op == OP_MUL) rsp_result <= bus.alu_result;
            else rsp_result <= {{WIDTH{1'b0}}, bus.alu_result[WIDTH-1:0]};
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_op <= head_op;
              alu_a  <= head_a;
              alu_b  <= head_b;
              cnt    <= head_cnt;
              state  <= DRIVE;
            end else begin
              alu_op <= '0;
              alu_a  <= '0;
              alu_b  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_L      = alu_op[2];
  assign bus.alu_M      = alu_op[1];
  assign bus.alu_N      = alu_op[0];
  assign bus.alu_A      = alu_a;
  assign bus.alu_B      = alu_b;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_op     = rsp_op;
  assign bus.rsp_result = rsp_result;
  assign bus.busy       = (state != IDLE) | ~empty;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stub.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(4), .DEPTH(4)) bus ();

  alu_op_sequencer #(
    .WIDTH(4), .DEPTH(4), .SETTLE(1), .MUL_SETTLE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ALU stub: 011 add, 111 multiply, 001 fixed pattern, others {A,B}.
  logic [2:0] stub_op;
  always_comb begin
    stub_op = {bus.alu_L, bus.alu_M, bus.alu_N};
    case (stub_op)
      3'b011:  bus.alu_result = {3'b000, {1'b0, bus.alu_A} + {1'b0, bus.alu_B}};
      3'b111:  bus.alu_result = {4'b0000, bus.alu_A} * {4'b0000, bus.alu_B};
      3'b001:  bus.alu_result = 8'hA7;
      default: bus.alu_result = {bus.alu_A, bus.alu_B};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [2:0] op, input logic [7:0] res);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_op"}, 32'(bus.rsp_op), 32'(op));
    check({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
  endtask

  logic [2:0] f_op  [5] = '{3'b011, 3'b000, 3'b011, 3'b110, 3'b011};
  logic [3:0] f_a   [5] = '{4'h1, 4'h3, 4'h7, 4'hC, 4'h6};
  logic [3:0] f_b   [5] = '{4'h1, 4'h9, 4'h8, 4'h5, 4'h1};
  logic [7:0] f_res [5] = '{8'h02, 8'h09, 8'h0F, 8'h05, 8'h07};

  initial begin
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.busy, bus.fifo_count,
                              bus.alu_L, bus.alu_M, bus.alu_N, bus.alu_A, bus.alu_B}), 32'd0);
    reset = 1'b0;
    check("rdy_before_clk", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("rdy_after_clk", 32'(bus.cmd_ready), 32'd1);

    // 1: add 5+3, two-cycle latency
    bus.rsp_ready = 1'b1;
    push(3'b011, 4'h5, 4'h3);
    check("add_queued", 32'({bus.fifo_count, bus.busy, bus.rsp_valid}), 32'({3'd1, 1'b1, 1'b0}));
    @(negedge clk);
    check("add_drive", 32'({bus.alu_L, bus.alu_M, bus.alu_N, bus.alu_A, bus.alu_B}), 32'({3'b011, 4'h5, 4'h3}));
    check("add_no_rsp_yet", 32'({bus.rsp_valid, bus.fifo_count}), 32'd0);
    @(negedge clk);
    check("add_rsp", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_result}), 32'({1'b1, 3'b011, 8'h08}));
    @(negedge clk);
    check("add_idle", 32'({bus.rsp_valid, bus.busy, bus.alu_L, bus.alu_M, bus.alu_N,
                           bus.alu_A, bus.alu_B}), 32'd0);

    // 3: multiply held for four cycles
    push(3'b111, 4'hF, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mul_hold", 32'({bus.rsp_valid, bus.alu_L, bus.alu_M, bus.alu_N, bus.alu_A, bus.alu_B}),
            32'({1'b0, 3'b111, 4'hF, 4'hF}));
    end
    @(negedge clk);
    check("mul_rsp", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_result}), 32'({1'b1, 3'b111, 8'hE1}));
    @(negedge clk);
    check("mul_done", 32'({bus.rsp_valid, bus.busy}), 32'd0);

    // 4: backpressure with one op queued behind
    bus.rsp_ready = 1'b0;
    push(3'b011, 4'h2, 4'h4);
    push(3'b010, 4'h1, 4'h1);
    wait_rsp("bp_first", 3'b011, 8'h06);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.alu_L, bus.alu_M,
                            bus.alu_N, bus.alu_A, bus.alu_B, bus.fifo_count}),
            32'({1'b1, 3'b011, 8'h06, 3'b011, 4'h2, 4'h4, 3'd1}));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_next_drive", 32'({bus.rsp_valid, bus.alu_L, bus.alu_M, bus.alu_N, bus.alu_A, bus.alu_B}),
          32'({1'b0, 3'b010, 4'h1, 4'h1}));
    @(negedge clk);
    check("bp_second", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_result}), 32'({1'b1, 3'b010, 8'h01}));
    @(negedge clk);

    // 5: non-multiply upper half masked
    push(3'b001, 4'h0, 4'h0);
    wait_rsp("mask", 3'b001, 8'h07);
    @(negedge clk);

    // 2: fill the queue with the response channel stalled
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(f_op[i], f_a[i], f_b[i]);
    check("fill_count", 32'({bus.fifo_count, bus.cmd_ready}), 32'({3'd4, 1'b0}));
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b101;
    bus.cmd_a     = 4'h2;
    bus.cmd_b     = 4'h2;
    repeat (3) @(negedge clk);
    check("fill_reject", 32'({bus.fifo_count, bus.cmd_ready, bus.rsp_valid}), 32'({3'd4, 1'b0, 1'b1}));
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("drain", f_op[i], f_res[i]);
      @(negedge clk);
    end
    check("drain_idle", 32'({bus.busy, bus.fifo_count, bus.rsp_valid}), 32'd0);

    // 6: reset while driving a multiply with two ops queued
    push(3'b111, 4'h3, 4'h3);
    push(3'b011, 4'h1, 4'h2);
    push(3'b011, 4'h2, 4'h2);
    check("rst_pre", 32'({bus.fifo_count, bus.alu_L, bus.alu_M, bus.alu_N, bus.rsp_valid}),
          32'({3'd2, 3'b111, 1'b0}));
    reset = 1'b1;
    #1;
    check("rst_async", 32'({bus.cmd_ready, bus.rsp_valid, bus.busy, bus.fifo_count,
                            bus.alu_L, bus.alu_M, bus.alu_N, bus.alu_A, bus.alu_B}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    check("rst_final", 32'({bus.fifo_count, bus.busy, bus.cmd_ready}), 32'({3'd0, 1'b0, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
